ofm_write_ctrl: RTL and testbench

- Output write-back stage directly downstream of the systolic array and its main controller.
- Accepts one row of SYSTOLIC_SIZE accumulated results per handshake from the array drain path, buffers it in a small FIFO, and applies shift/ReLU/saturation.
- Writes one packed pixel word (SYSTOLIC_SIZE output channels) per accepted RAM transaction into the OFM RAM.
- Generates OFM addresses across pixels and filter groups, and pulses done when the whole layer is written.

---
 rtl/ofm_write_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ofm_write_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_write_ctrl.sv
// OFM write-back stage: buffers accumulated rows from the systolic array, applies
// shift/ReLU/saturation per lane and writes one packed pixel word per RAM transaction.
module ofm_write_ctrl #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int NO_FILTER     = 16,
    parameter int OFM_PIXELS    = 172224,
    parameter int ACC_W         = 32,
    parameter int OUT_W         = 16,
    parameter int FRAC_SHIFT    = 8,
    parameter int RELU_EN       = 1,
    parameter int FIFO_DEPTH    = 4,
    parameter int ADDR_W        = 22
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             res_valid,
    input  logic [SYSTOLIC_SIZE*ACC_W-1:0]   res_data,
    output logic                             res_ready,
    output logic                             ofm_we,
    input  logic                             ofm_ready,
    output logic [ADDR_W-1:0]                ofm_addr,
    output logic [SYSTOLIC_SIZE*OUT_W-1:0]   ofm_wdata,
    output logic                             busy,
    output logic                             done
);

    localparam int NO_GROUP = (NO_FILTER + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [ADDR_W:0]   TOTAL_ROWS = (ADDR_W+1)'(NO_GROUP * OFM_PIXELS);
    localparam logic [ADDR_W-1:0] PIX_LAST   = ADDR_W'(OFM_PIXELS - 1);
    localparam logic [ADDR_W-1:0] PIX_STEP   = ADDR_W'(OFM_PIXELS);
    localparam logic [ADDR_W-1:0] GROUP_LAST = ADDR_W'(NO_GROUP - 1);
    localparam logic [PTR_W:0]    DEPTH_C    = (PTR_W+1)'(FIFO_DEPTH);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                            r_state;
    logic [SYSTOLIC_SIZE*ACC_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]                  r_wrPtr;
    logic [PTR_W-1:0]                  r_rdPtr;
    logic [PTR_W:0]                    r_count;
    logic [ADDR_W:0]                   r_pushCnt;
    logic [ADDR_W-1:0]                 r_pixel;
    logic [ADDR_W-1:0]                 r_group;
    logic [ADDR_W-1:0]                 r_base;
    logic                              r_we;
    logic                              r_lastLoaded;
    logic [ADDR_W-1:0]                 r_addr;
    logic [SYSTOLIC_SIZE*OUT_W-1:0]    r_wdata;
    logic                              r_busy;
    logic                              r_done;

    logic                              w_resReady;
    logic                              w_push;
    logic                              w_load;
    logic                              w_accept;
    logic [SYSTOLIC_SIZE*ACC_W-1:0]    w_head;
    logic [SYSTOLIC_SIZE*OUT_W-1:0]    w_proc;

    function automatic logic [OUT_W-1:0] processLane(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] s;
        s = acc >>> FRAC_SHIFT;
        if ((RELU_EN != 0) && s[ACC_W-1])
            s = '0;
        if (s > SAT_MAX)
            s = SAT_MAX;
        else if (s < SAT_MIN)
            s = SAT_MIN;
        return s[OUT_W-1:0];
    endfunction

    // Stop accepting once every row of the layer has entered the FIFO.
    assign w_resReady = (r_state == RUN) && (r_count != DEPTH_C) && (r_pushCnt != TOTAL_ROWS);
    assign w_push     = res_valid && w_resReady;
    assign w_load     = (r_state == RUN) && (!r_we || ofm_ready) && (r_count != '0);
    assign w_accept   = r_we && ofm_ready;
    assign w_head     = r_mem[r_rdPtr];

    always_comb begin
        w_proc = '0;
        for (int i = 0; i < SYSTOLIC_SIZE; i++)
            w_proc[i*OUT_W +: OUT_W] = processLane(w_head[i*ACC_W +: ACC_W]);
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wrPtr] <= res_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_count      <= '0;
            r_pushCnt    <= '0;
            r_pixel      <= '0;
            r_group      <= '0;
            r_base       <= '0;
            r_we         <= 1'b0;
            r_lastLoaded <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state      <= RUN;
                        r_wrPtr      <= '0;
                        r_rdPtr      <= '0;
                        r_count      <= '0;
                        r_pushCnt    <= '0;
                        r_pixel      <= '0;
                        r_group      <= '0;
                        r_base       <= '0;
                        r_we         <= 1'b0;
                        r_lastLoaded <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_push) begin
                        r_wrPtr   <= r_wrPtr + PTR_W'(1);
                        r_pushCnt <= r_pushCnt + (ADDR_W+1)'(1);
                    end
                    if (w_load)
                        r_rdPtr <= r_rdPtr + PTR_W'(1);
                    case ({w_push, w_load})
                        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                        default: r_count <= r_count;
                    endcase

                    // Address uses a running group base so no multiplier is needed.
                    if (w_load) begin
                        r_we         <= 1'b1;
                        r_addr       <= r_base + r_pixel;
                        r_wdata      <= w_proc;
                        r_lastLoaded <= (r_pixel == PIX_LAST) && (r_group == GROUP_LAST);
                        if (r_pixel == PIX_LAST) begin
                            r_pixel <= '0;
                            r_group <= r_group + ADDR_W'(1);
                            r_base  <= r_base + PIX_STEP;
                        end else begin
                            r_pixel <= r_pixel + ADDR_W'(1);
                        end
                    end else if (w_accept) begin
                        r_we <= 1'b0;
                    end

                    if (w_accept && r_lastLoaded) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign res_ready = w_resReady;
    assign ofm_we    = r_we;
    assign ofm_addr  = r_addr;
    assign ofm_wdata = r_wdata;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_ofm_write_ctrl.sv
// Testbench for ofm_write_ctrl: a small 4-lane, 2-group, 3-pixel layer driven from a
// table of rows with hand-computed packed outputs for ReLU on and off.
module tb_ofm_write_ctrl;

    localparam int SS     = 4;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 16;
    localparam int ADDR_W = 22;
    localparam int NROWS  = 6;

    typedef struct {
        logic [SS*ACC_W-1:0] row;
        logic [SS*OUT_W-1:0] expRelu;
        logic [SS*OUT_W-1:0] expNoRelu;
    } vec_t;

    vec_t vec [NROWS];

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  res_valid;
    logic [SS*ACC_W-1:0]   res_data;
    logic                  ofm_ready;

    logic                  res_ready, ofm_we, busy, done;
    logic [ADDR_W-1:0]     ofm_addr;
    logic [SS*OUT_W-1:0]   ofm_wdata;

    logic                  nrResReady, nrWe, nrBusy, nrDone;
    logic [ADDR_W-1:0]     nrAddr;
    logic [SS*OUT_W-1:0]   nrWdata;

    int compared;
    int mismatched;

    int                    cyc;
    logic [ADDR_W-1:0]     wrAddr [$];
    logic [SS*OUT_W-1:0]   wrData [$];
    logic [SS*OUT_W-1:0]   wrDataNr [$];
    int                    wrCyc [$];
    int                    acceptCyc [$];
    int                    doneCount;
    int                    doneCyc;

    ofm_write_ctrl #(
        .SYSTOLIC_SIZE(SS), .NO_FILTER(8), .OFM_PIXELS(3), .ACC_W(ACC_W), .OUT_W(OUT_W),
        .FRAC_SHIFT(8), .RELU_EN(1), .FIFO_DEPTH(4), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .ofm_we(ofm_we), .ofm_ready(ofm_ready), .ofm_addr(ofm_addr),
        .ofm_wdata(ofm_wdata), .busy(busy), .done(done)
    );

    ofm_write_ctrl #(
        .SYSTOLIC_SIZE(SS), .NO_FILTER(8), .OFM_PIXELS(3), .ACC_W(ACC_W), .OUT_W(OUT_W),
        .FRAC_SHIFT(8), .RELU_EN(0), .FIFO_DEPTH(4), .ADDR_W(ADDR_W)
    ) dutNoRelu (
        .clk(clk), .rst(rst), .start(start), .res_valid(res_valid), .res_data(res_data),
        .res_ready(nrResReady), .ofm_we(nrWe), .ofm_ready(ofm_ready), .ofm_addr(nrAddr),
        .ofm_wdata(nrWdata), .busy(nrBusy), .done(nrDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Log accepted rows, accepted writes and done pulses with their cycle numbers.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (res_valid && res_ready)
            acceptCyc.push_back(cyc);
        if (ofm_we && ofm_ready) begin
            wrAddr.push_back(ofm_addr);
            wrData.push_back(ofm_wdata);
            wrCyc.push_back(cyc);
        end
        if (nrWe && ofm_ready)
            wrDataNr.push_back(nrWdata);
        if (done) begin
            doneCount = doneCount + 1;
            doneCyc   = cyc;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clearLog();
        wrAddr.delete();
        wrData.delete();
        wrDataNr.delete();
        wrCyc.delete();
        acceptCyc.delete();
        doneCount = 0;
        doneCyc   = 0;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        start     = 1'b0;
        res_valid = 1'b0;
        ofm_ready = 1'b1;
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offer rows first..last-1 in order, advancing only when res_ready was high.
    task automatic applyStimulus(input int first, input int last, input int maxCycles);
        int   k;
        int   n;
        logic wasReady;
        k = first;
        n = 0;
        while (k < last && n < maxCycles) begin
            res_data  = vec[k].row;
            res_valid = 1'b1;
            wasReady  = res_ready;
            @(posedge clk);
            #1;
            if (wasReady)
                k++;
            n++;
        end
        res_valid = 1'b0;
        checkOutput("rowsPushed", 64'(k), 64'(last));
    endtask

    task automatic waitDone(input int target, input int maxCycles);
        int n;
        n = 0;
        while (doneCount < target && n < maxCycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("doneSeen", 64'(doneCount), 64'(target));
    endtask

    task automatic checkWrites(input string tag);
        checkOutput({tag, "_writeCount"}, 64'(wrAddr.size()), 64'(NROWS));
        for (int i = 0; i < NROWS; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i),
                        (i < wrAddr.size()) ? 64'(wrAddr[i]) : 'x, 64'(i));
            checkOutput($sformatf("%s_wdata%0d", tag, i),
                        (i < wrData.size()) ? 64'(wrData[i]) : 'x, 64'(vec[i].expRelu));
            checkOutput($sformatf("%s_wdataNoRelu%0d", tag, i),
                        (i < wrDataNr.size()) ? 64'(wrDataNr[i]) : 'x, 64'(vec[i].expNoRelu));
        end
    endtask

    initial begin
        vec[0] = '{128'h00001234_7FFFFFFF_FFFFFF00_00000100,
                   64'h0012_7FFF_0000_0001, 64'h0012_7FFF_FFFF_0001};
        vec[1] = '{128'h00800000_007FFF00_00000000_80000000,
                   64'h7FFF_7FFF_0000_0000, 64'h7FFF_7FFF_0000_8000};
        vec[2] = '{128'h00000200_000000FF_FF7FFF00_FF800000,
                   64'h0002_0000_0000_0000, 64'h0002_0000_8000_8000};
        vec[3] = '{128'h00010000_0000ABCD_FFFFFE00_12345678,
                   64'h0100_00AB_0000_7FFF, 64'h0100_00AB_FFFE_7FFF};
        vec[4] = '{128'h00400000_FFFFFFFF_00000180_00000001,
                   64'h4000_0000_0001_0000, 64'h4000_FFFF_0001_0000};
        vec[5] = '{128'h7FFF0000_00002000_FFFF0000_00000A00,
                   64'h7FFF_0020_0000_000A, 64'h7FFF_0020_FF00_000A};

        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        res_data   = '0;
        clearLog();

        // Reset values.
        rst       = 1'b1;
        start     = 1'b0;
        res_valid = 1'b0;
        ofm_ready = 1'b1;
        #1;
        checkOutput("rst_resReady", 64'(res_ready), 64'd0);
        checkOutput("rst_ofmWe", 64'(ofm_we), 64'd0);
        checkOutput("rst_addr", 64'(ofm_addr), 64'd0);
        checkOutput("rst_wdata", 64'(ofm_wdata), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        doReset();

        // Rows offered in IDLE are never accepted.
        $display("[TB] rows offered while idle");
        res_valid = 1'b1;
        res_data  = vec[0].row;
        for (int i = 0; i < 3; i++) begin
            checkOutput("idle_resReady", 64'(res_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        res_valid = 1'b0;
        checkOutput("idle_noWrite", 64'(wrAddr.size() + acceptCyc.size()), 64'd0);

        // Full layer back-to-back, then a 7th row that must be refused.
        $display("[TB] full layer");
        clearLog();
        pulseStart();
        checkOutput("run_busy", 64'(busy), 64'd1);
        applyStimulus(0, NROWS, 30);
        res_valid = 1'b1;
        res_data  = vec[0].row;
        checkOutput("extraRow_resReady", 64'(res_ready), 64'd0);
        checkOutput("extraRow_busy", 64'(busy), 64'd1);
        waitDone(1, 40);
        res_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("full_acceptCount", 64'(acceptCyc.size()), 64'(NROWS));
        checkOutput("full_doneOnce", 64'(doneCount), 64'd1);
        checkOutput("full_busyAfter", 64'(busy), 64'd0);
        checkWrites("full");
        if (wrCyc.size() == NROWS && acceptCyc.size() > 0) begin
            checkOutput("full_latency", 64'(wrCyc[0] - acceptCyc[0]), 64'd2);
            checkOutput("full_throughput", 64'(wrCyc[NROWS-1] - wrCyc[0]), 64'(NROWS - 1));
            checkOutput("full_doneTiming", 64'(doneCyc - wrCyc[NROWS-1]), 64'd1);
        end else begin
            checkOutput("full_timingLog", 64'(wrCyc.size()), 64'(NROWS));
        end

        // Backpressure: RAM stalls for 10 cycles while rows keep coming; start is ignored.
        $display("[TB] backpressure");
        doReset();
        clearLog();
        pulseStart();
        ofm_ready = 1'b0;
        begin
            int   k;
            logic wasReady;
            k = 0;
            for (int i = 0; i < 10; i++) begin
                res_data  = vec[k].row;
                res_valid = 1'b1;
                start     = (i == 6);
                wasReady  = res_ready;
                @(posedge clk);
                #1;
                if (wasReady)
                    k++;
                if (i >= 1) begin
                    checkOutput("stall_we", 64'(ofm_we), 64'd1);
                    checkOutput("stall_addr", 64'(ofm_addr), 64'd0);
                    checkOutput("stall_wdata", 64'(ofm_wdata), 64'(vec[0].expRelu));
                end
            end
            start     = 1'b0;
            res_valid = 1'b0;
            checkOutput("stall_rowsAccepted", 64'(k), 64'd5);
            checkOutput("stall_resReady", 64'(res_ready), 64'd0);
            checkOutput("stall_busy", 64'(busy), 64'd1);
            ofm_ready = 1'b1;
            applyStimulus(k, NROWS, 30);
        end
        waitDone(1, 40);
        checkWrites("bp");

        // Reset with rows buffered abandons the layer; a new start begins at address 0.
        $display("[TB] reset mid-run");
        doReset();
        clearLog();
        pulseStart();
        applyStimulus(0, 3, 20);
        ofm_ready = 1'b0;
        applyStimulus(3, 5, 20);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midRst_resReady", 64'(res_ready), 64'd0);
        checkOutput("midRst_we", 64'(ofm_we), 64'd0);
        checkOutput("midRst_addr", 64'(ofm_addr), 64'd0);
        checkOutput("midRst_wdata", 64'(ofm_wdata), 64'd0);
        checkOutput("midRst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst       = 1'b0;
        ofm_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("midRst_noDone", 64'(doneCount), 64'd0);
        clearLog();
        pulseStart();
        applyStimulus(0, NROWS, 30);
        waitDone(1, 40);
        checkWrites("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
